fpc_enc_pipe: RTL and testbench
===============================

Name: fpc_enc_pipe

Overview:
Parametrised forbidden-pattern-code (FPC) bus encoder with a streaming valid/ready interface. It splits an input word of LANES nibbles and maps each nibble to a 5-bit codeword free of the patterns 010 and 101. Codewords are buffered in a 2-entry skid pipeline, so the wire-side bus holds its last codeword when idle. It sits between the core datapath and the long inter-block bus, replacing the fixed 8-lane registered encoder.

Parameters:
LANES, 8, number of 4-bit input lanes (1..16)
CNT_W, 16, width of the delivered-word counter
(derived, not overridable) OUT_W = LANES*5, or LANES*6-1 with FPC_SHIELD_EN

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low
in_data  input  LANES*4  raw word; lane i = in_data[4i+3:4i]
in_valid  input  1  in_data valid
in_ready  output  1  encoder can accept a word
out_data  output  OUT_W  encoded bus; lane i codeword = out_data[5i+4:5i] (no shield)
out_valid  output  1  out_data holds an undelivered word
out_ready  input  1  sink accepts out_data
cnt_clr  input  1  synchronous clear of word_cnt
word_cnt  output  CNT_W  saturating count of delivered words

Behaviour:
- Reset is asynchronous, active-low, on clk. While rst=0: out_data=0, out_valid=0, in_ready=0, word_cnt=0, skid entry empty. First cycle after release: in_ready=1.
- Codebook, nibble value 0..15 to codeword in decimal: 0,1,3,6,7,12,14,15,16,17,19,24,25,28,30,31. The map is monotonic. Codes for 8..15 are bitwise complements of codes for 7..0.
- Encoding is combinational on in_data at accept time. Only registered values drive out_data.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: output register full, skid empty, in_ready=1.
  - TWO: output and skid full, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE. The word is loaded into the output register. Latency is 1 cycle from accept to out_valid.
  - ONE + accept + deliver -> ONE. The new word replaces the output register.
  - ONE + accept, no deliver -> TWO. The word goes to skid.
  - ONE + deliver, no accept -> EMPTY.
  - TWO + deliver -> ONE. Skid moves to the output register. No accept is possible in TWO.
- in_ready is a register output and has no combinational path from out_ready.
- Word order is strictly preserved. No drop or duplication under any backpressure pattern.
- When out_valid=0, out_data holds the last delivered codeword and does not toggle (crosstalk/power). It returns to 0 only by reset.
- word_cnt: +1 on deliver and saturates at all-ones. cnt_clr has priority: when cnt_clr and deliver occur in the same cycle, the result is 0.
- in_data and in_valid are ignored when in_ready=0.
- Asserting rst mid-transfer discards output and skid contents immediately.
- Inter-lane boundaries are not FP-free without the shield option.

Optional Feature:
FPC_SHIELD_EN
- Defined: one constant-0 shield bit is inserted between adjacent lane codewords. OUT_W=LANES*6-1. Lane i occupies out_data[6i+4:6i] and the shield is bit 6i+5 (i<LANES-1). Shield bits are 0 in reset and in all states.
- Undefined: lanes are packed contiguously and OUT_W=LANES*5. Handshake and timing are identical in both builds.

Test Plan:
- Reset values: hold rst=0 with random inputs -> out_data=0, out_valid=0, in_ready=0, word_cnt=0. Release rst -> in_ready=1 next cycle.
- Codebook (LANES=8, out_ready=1): accept 32'h7654_3210 -> next cycle out_data=40'h7B_9873_0C20, out_valid=1. Accept 32'hFFFF_FFFF -> 40'hFF_FFFF_FFFF. Accept 32'h0 -> 40'h0.
- Backpressure: out_ready=0, offer A=1, B=2, C=3 on consecutive cycles. A and B are accepted and in_ready drops after B; C is held. Raise out_ready -> outputs A, B, C in order with one deliver per cycle. No loss.
- Idle hold: after delivering 32'h7654_3210, drop in_valid for 10 cycles -> out_data stays 40'h7B_9873_0C20 and out_valid=0.
- Counter (CNT_W=4): 17 delivers -> word_cnt=15. Then cnt_clr together with a deliver -> word_cnt=0.
- Reset mid-op and shield: in state TWO, pulse rst -> outputs reset within the cycle and no stale word is delivered afterwards. With FPC_SHIELD_EN and LANES=8, accept 32'hFFFF_FFFF -> out_data=47 bits with bits 5,11,17,23,29,35,41 = 0 and all other bits = 1.

Source files
------------

// File: rtl/fpc_enc_pipe.sv
// fpc_enc_pipe: forbidden-pattern-code bus encoder with a 2-entry skid pipeline.
// Each 4-bit input lane maps to a 5-bit codeword free of the patterns 010 and 101.
// Codewords are registered before they reach the bus. When no word is pending,
// the bus keeps the last codeword, so the long wires do not toggle while idle.
// Optional build macro: FPC_SHIELD_EN places a constant-0 shield bit between
// adjacent lane codewords. This makes the lane boundaries FP-free as well.
module fpc_enc_pipe #(
  parameter int LANES = 8,
  parameter int CNT_W = 16,
`ifdef FPC_SHIELD_EN
  localparam int STRIDE = 6,
  localparam int OUT_W  = LANES*6-1
`else
  localparam int STRIDE = 5,
  localparam int OUT_W  = LANES*5
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES*4-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   word_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Nibble to codeword. The map is monotonic.
  // Codes for 8..15 are the bitwise complements of the codes for 7..0.
  function automatic logic [4:0] fpc_code(input logic [3:0] nib);
    logic [4:0] code;
    case (nib)
      4'd0:    code = 5'd0;
      4'd1:    code = 5'd1;
      4'd2:    code = 5'd3;
      4'd3:    code = 5'd6;
      4'd4:    code = 5'd7;
      4'd5:    code = 5'd12;
      4'd6:    code = 5'd14;
      4'd7:    code = 5'd15;
      4'd8:    code = 5'd16;
      4'd9:    code = 5'd17;
      4'd10:   code = 5'd19;
      4'd11:   code = 5'd24;
      4'd12:   code = 5'd25;
      4'd13:   code = 5'd28;
      4'd14:   code = 5'd30;
      4'd15:   code = 5'd31;
      default: code = 5'd0;
    endcase
    return code;
  endfunction

  state_t             state_r;
  state_t             state_nxt;
  logic [OUT_W-1:0]   out_data_r;
  logic [OUT_W-1:0]   skid_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic [CNT_W-1:0]   word_cnt_r;

  logic [OUT_W-1:0]   enc_s;
  logic               accept_s;
  logic               deliver_s;
  logic               load_out_enc_s;
  logic               load_out_skid_s;
  logic               load_skid_s;

  assign accept_s  = in_valid & in_ready_r;
  assign deliver_s = out_valid_r & out_ready;

  // Encode every lane of the incoming word. Shield positions stay 0.
  always_comb begin
    enc_s = '0;
    for (int i = 0; i < LANES; i++) begin
      enc_s[i*STRIDE +: 5] = fpc_code(in_data[i*4 +: 4]);
    end
  end

  // Next-state and datapath steering for the skid pipeline.
  always_comb begin
    state_nxt       = state_r;
    load_out_enc_s  = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt      = ONE;
          load_out_enc_s = 1'b1;
        end else begin
          state_nxt = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && deliver_s) begin
          state_nxt      = ONE;
          load_out_enc_s = 1'b1;
        end else if (accept_s) begin
          state_nxt   = TWO;
          load_skid_s = 1'b1;
        end else if (deliver_s) begin
          state_nxt = EMPTY;
        end else begin
          state_nxt = ONE;
        end
      end
      TWO: begin
        // in_ready is low in TWO, so only a deliver can move the pipe.
        if (deliver_s) begin
          state_nxt       = ONE;
          load_out_skid_s = 1'b1;
        end else begin
          state_nxt = TWO;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // State plus registered handshake flags. These are decoded from next state,
  // so in_ready has no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      out_valid_r <= (state_nxt != EMPTY);
      in_ready_r  <= (state_nxt != TWO);
    end
  end

  // Output and skid registers. out_data only changes when a new word lands,
  // so it holds the last delivered codeword while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_r <= '0;
      skid_r     <= '0;
    end else begin
      if (load_out_enc_s) begin
        out_data_r <= enc_s;
      end else if (load_out_skid_s) begin
        out_data_r <= skid_r;
      end else begin
        out_data_r <= out_data_r;
      end
      if (load_skid_s) begin
        skid_r <= enc_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  // Saturating delivered-word counter; clear wins over a same-cycle deliver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_r <= '0;
    end else if (cnt_clr) begin
      word_cnt_r <= '0;
    end else if (deliver_s && (word_cnt_r != {CNT_W{1'b1}})) begin
      word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_fpc_enc_pipe.sv
// Directed self-checking bench for fpc_enc_pipe (LANES=8, CNT_W=4).
// It checks reset, the codebook, backpressure ordering, idle hold,
// counter saturation and clear, and reset while the skid is full.
module tb_fpc_enc_pipe;

  localparam int LANES = 8;
  localparam int CNT_W = 4;
`ifdef FPC_SHIELD_EN
  localparam int OUT_W = LANES*6-1;
  localparam logic [OUT_W-1:0] EXP_7654 = 47'h3CE307183040;
  localparam logic [OUT_W-1:0] EXP_FFFF = 47'h7DF7DF7DF7DF;
`else
  localparam int OUT_W = LANES*5;
  localparam logic [OUT_W-1:0] EXP_7654 = 40'h7B98730C20;
  localparam logic [OUT_W-1:0] EXP_FFFF = 40'hFFFFFFFFFF;
`endif

  logic               clk;
  logic               rst;
  logic [LANES*4-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               cnt_clr;
  logic [CNT_W-1:0]   word_cnt;

  int checks;
  int failures;

  fpc_enc_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset held with random inputs.
    for (int k = 0; k < 4; k++) begin
      in_data   = $urandom;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cnt_clr   = 1'($urandom_range(0, 1));
      tick();
      check_val("rst_out_data", 64'(out_data), 64'h0);
      check_val("rst_out_valid", 64'(out_valid), 64'h0);
      check_val("rst_in_ready", 64'(in_ready), 64'h0);
      check_val("rst_word_cnt", 64'(word_cnt), 64'h0);
    end
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    rst       = 1'b1;
    tick();
    check_val("post_rst_in_ready", 64'(in_ready), 64'h1);
    check_val("post_rst_out_valid", 64'(out_valid), 64'h0);

    // Codebook with the sink always ready.
    in_data  = 32'h7654_3210;
    in_valid = 1'b1;
    tick();
    check_val("cb_7654_data", 64'(out_data), 64'(EXP_7654));
    check_val("cb_7654_valid", 64'(out_valid), 64'h1);
    in_data = 32'hFFFF_FFFF;
    tick();
    check_val("cb_ffff_data", 64'(out_data), 64'(EXP_FFFF));
    in_data = 32'h0000_0000;
    tick();
    check_val("cb_zero_data", 64'(out_data), 64'h0);
    in_valid = 1'b0;
    tick();
    check_val("cb_drain_valid", 64'(out_valid), 64'h0);
    check_val("cb_word_cnt", 64'(word_cnt), 64'd3);

    // Idle hold: after delivery the bus keeps the last codeword.
    in_data  = 32'h7654_3210;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hA5A5_A5A5;
    tick();
    for (int k = 0; k < 10; k++) begin
      check_val("idle_data", 64'(out_data), 64'(EXP_7654));
      check_val("idle_valid", 64'(out_valid), 64'h0);
      tick();
    end

    // Backpressure: A, B accepted, C held until the sink drains.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    tick();
    check_val("bp_a_ready", 64'(in_ready), 64'h1);
    in_data = 32'h2;
    tick();
    check_val("bp_b_ready", 64'(in_ready), 64'h0);
    in_data = 32'h3;
    tick();
    check_val("bp_hold_data", 64'(out_data), 64'h1);
    check_val("bp_hold_ready", 64'(in_ready), 64'h0);
    out_ready = 1'b1;
    tick();
    check_val("bp_b_data", 64'(out_data), 64'h3);
    check_val("bp_b_valid", 64'(out_valid), 64'h1);
    tick();
    in_valid = 1'b0;
    check_val("bp_c_data", 64'(out_data), 64'h6);
    check_val("bp_c_valid", 64'(out_valid), 64'h1);
    tick();
    check_val("bp_done_valid", 64'(out_valid), 64'h0);
    check_val("bp_word_cnt", 64'(word_cnt), 64'd7);

    // Counter: clear, count to saturation, then clear with a deliver.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_val("cnt_clear", 64'(word_cnt), 64'd0);
    in_valid = 1'b1;
    in_data  = 32'h0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 15) check_val("cnt_14", 64'(word_cnt), 64'd14);
      if (k == 16) check_val("cnt_15", 64'(word_cnt), 64'd15);
    end
    check_val("cnt_sat", 64'(word_cnt), 64'd15);
    cnt_clr = 1'b1;
    check_val("cnt_clr_with_deliver_valid", 64'(out_valid), 64'h1);
    tick();
    check_val("cnt_clr_with_deliver", 64'(word_cnt), 64'd0);
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    tick();
    check_val("cnt_after_clr", 64'(word_cnt), 64'd1);

    // Reset in state TWO discards both entries at once.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    check_val("mid_a_data", 64'(out_data), 64'hC);
    in_data = 32'h6;
    tick();
    check_val("mid_two_ready", 64'(in_ready), 64'h0);
    rst = 1'b0;
    #1;
    check_val("mid_rst_data", 64'(out_data), 64'h0);
    check_val("mid_rst_valid", 64'(out_valid), 64'h0);
    check_val("mid_rst_ready", 64'(in_ready), 64'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check_val("mid_rel_ready", 64'(in_ready), 64'h1);
    check_val("mid_rel_valid", 64'(out_valid), 64'h0);
    tick();
    check_val("mid_no_stale_valid", 64'(out_valid), 64'h0);
    check_val("mid_no_stale_data", 64'(out_data), 64'h0);
    check_val("mid_word_cnt", 64'(word_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
